// File: rtl/narrow_pkg.sv
// rtl/narrow_pkg.sv - shared types and constants for the word_narrow datapath
package narrow_pkg;

    localparam int OUT_W_DEF = 16;

    localparam logic MODE_SPLIT  = 1'b0;
    localparam logic MODE_NARROW = 1'b1;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_LO    = 2'd1,
        ST_HI    = 2'd2
    } state_t;

endpackage

// File: rtl/narrow_check.sv
// rtl/narrow_check.sv - range check and narrowing of one 2*OUT_W word to OUT_W bits
// NARROW_SAT_EN: out-of-range values saturate instead of truncating.
module narrow_check
    import narrow_pkg::*;
#(
    parameter int OUT_W = OUT_W_DEF
) (
    input  logic [2*OUT_W-1:0] i_word,
    input  logic               i_sign,
    output logic               o_ovf,
    output logic [OUT_W-1:0]   o_half
);

    logic [OUT_W-1:0] w_lo;
    logic [OUT_W-1:0] w_hi;
    logic [OUT_W-1:0] w_ext;

    assign w_lo  = i_word[OUT_W-1:0];
    assign w_hi  = i_word[2*OUT_W-1:OUT_W];
    // The upper half must equal what 16->32 extension of the lower half would produce.
    assign w_ext = i_sign ? {OUT_W{w_lo[OUT_W-1]}} : '0;
    assign o_ovf = (w_hi != w_ext);

`ifdef NARROW_SAT_EN
    logic [OUT_W-1:0] w_sat;

    assign w_sat  = i_sign ? {i_word[2*OUT_W-1], {(OUT_W-1){~i_word[2*OUT_W-1]}}} : '1;
    assign o_half = o_ovf ? w_sat : w_lo;
`else
    assign o_half = w_lo;
`endif

endmodule

// File: rtl/word_narrow.sv
// rtl/word_narrow.sv - narrows a stream of 2*OUT_W words into OUT_W halfwords (SPLIT / NARROW)
// NARROW_SAT_EN selects saturation inside narrow_check; default build truncates.
module word_narrow
    import narrow_pkg::*;
#(
    parameter int OUT_W = OUT_W_DEF
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               in_valid_i,
    output logic               in_ready_o,
    input  logic [2*OUT_W-1:0] in_data_i,
    input  logic               mode_i,
    input  logic               sign_i,
    output logic               out_valid_o,
    input  logic               out_ready_i,
    output logic [OUT_W-1:0]   out_data_o,
    output logic               out_last_o,
    output logic               ovf_o
);

    localparam int IN_W = 2 * OUT_W;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [IN_W-1:0]   r_word;
    logic              r_mode;
    logic              r_sign;

    logic              r_out_valid;
    logic [OUT_W-1:0]  r_out_data;
    logic              r_out_last;
    logic              r_ovf;

    logic              w_last_shown;
    logic              w_accept;
    logic              w_out_hs;
    logic [IN_W-1:0]   w_word_nxt;
    logic              w_mode_nxt;
    logic              w_sign_nxt;
    logic              w_ovf;
    logic [OUT_W-1:0]  w_half;
    logic              w_valid_nxt;
    logic [OUT_W-1:0]  w_data_nxt;
    logic              w_last_nxt;
    logic              w_ovf_nxt;

    assign w_last_shown = ((r_state == ST_LO) && (r_mode == MODE_NARROW)) || (r_state == ST_HI);
    assign in_ready_o   = (r_state == ST_EMPTY) || (w_last_shown && out_ready_i);
    assign w_accept     = in_valid_i && in_ready_o;
    assign w_out_hs     = r_out_valid && out_ready_i;

    assign w_word_nxt = w_accept ? in_data_i : r_word;
    assign w_mode_nxt = w_accept ? mode_i    : r_mode;
    assign w_sign_nxt = w_accept ? sign_i    : r_sign;

    // Outputs are computed from the next word so they can be registered with zero extra latency.
    narrow_check #(.OUT_W(OUT_W)) u_check (
        .i_word (w_word_nxt),
        .i_sign (w_sign_nxt),
        .o_ovf  (w_ovf),
        .o_half (w_half)
    );

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_EMPTY: begin
                if (w_accept) w_state_nxt = ST_LO;
            end
            ST_LO: begin
                if (w_out_hs) begin
                    if (r_mode == MODE_SPLIT) w_state_nxt = ST_HI;
                    else                      w_state_nxt = w_accept ? ST_LO : ST_EMPTY;
                end
            end
            ST_HI: begin
                if (w_out_hs) w_state_nxt = w_accept ? ST_LO : ST_EMPTY;
            end
            default: w_state_nxt = ST_EMPTY;
        endcase
    end

    always_comb begin
        w_valid_nxt = (w_state_nxt != ST_EMPTY);
        w_data_nxt  = '0;
        w_last_nxt  = 1'b0;
        w_ovf_nxt   = 1'b0;
        case (w_state_nxt)
            ST_LO: begin
                if (w_mode_nxt == MODE_SPLIT) begin
                    w_data_nxt = w_word_nxt[OUT_W-1:0];
                end else begin
                    w_data_nxt = w_half;
                    w_last_nxt = 1'b1;
                    w_ovf_nxt  = w_ovf;
                end
            end
            ST_HI: begin
                w_data_nxt = w_word_nxt[IN_W-1:OUT_W];
                w_last_nxt = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state     <= ST_EMPTY;
            r_word      <= '0;
            r_mode      <= MODE_SPLIT;
            r_sign      <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_last  <= 1'b0;
            r_ovf       <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_word      <= w_word_nxt;
            r_mode      <= w_mode_nxt;
            r_sign      <= w_sign_nxt;
            r_out_valid <= w_valid_nxt;
            r_out_data  <= w_data_nxt;
            r_out_last  <= w_last_nxt;
            r_ovf       <= w_ovf_nxt;
        end
    end

    assign out_valid_o = r_out_valid;
    assign out_data_o  = r_out_data;
    assign out_last_o  = r_out_last;
    assign ovf_o       = r_ovf;

endmodule

// File: tb/tb_word_narrow.sv
// tb/tb_word_narrow.sv - self-checking bench for word_narrow (directed vectors plus a beat-queue model)
module tb_word_narrow;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        in_valid_i;
    logic        in_ready_o;
    logic [31:0] in_data_i;
    logic        mode_i;
    logic        sign_i;
    logic        out_valid_o;
    logic        out_ready_i;
    logic [15:0] out_data_o;
    logic        out_last_o;
    logic        ovf_o;

    always #5 clk = ~clk;

    word_narrow dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .in_data_i   (in_data_i),
        .mode_i      (mode_i),
        .sign_i      (sign_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .out_data_o  (out_data_o),
        .out_last_o  (out_last_o),
        .ovf_o       (ovf_o)
    );

`ifdef NARROW_SAT_EN
    localparam logic [15:0] T3A_DATA = 16'h7FFF;
    localparam logic [15:0] T3B_DATA = 16'hFFFF;
`else
    localparam logic [15:0] T3A_DATA = 16'h0000;
    localparam logic [15:0] T3B_DATA = 16'h0005;
`endif

    typedef struct {
        logic [15:0] d;
        logic        l;
        logic        o;
        int          c;
    } beat_t;

    beat_t exp_q[$];
    beat_t got_q[$];
    beat_t mon_b;
    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int n_exp_beats = 0;
    int n_got_beats = 0;
    logic [31:0] edge_w [6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Beats a word must produce, derived from the arithmetic meaning of the range check.
    task automatic model_push(input logic [31:0] w, input logic m, input logic s);
        beat_t b;
        int    sv;
        logic  ov;
        b.c = 0;
        if (m == 1'b0) begin
            b.d = w[15:0];  b.l = 1'b0; b.o = 1'b0; exp_q.push_back(b);
            b.d = w[31:16]; b.l = 1'b1; b.o = 1'b0; exp_q.push_back(b);
            n_exp_beats += 2;
        end else begin
            sv = $signed(w);
            ov = s ? ((sv < -32768) || (sv > 32767)) : (w > 32'h0000_FFFF);
            b.d = w[15:0];
`ifdef NARROW_SAT_EN
            if (ov) b.d = s ? ((sv < 0) ? 16'h8000 : 16'h7FFF) : 16'hFFFF;
`endif
            b.l = 1'b1;
            b.o = ov;
            exp_q.push_back(b);
            n_exp_beats += 1;
        end
    endtask

    // Compare process: inputs settle at negedge, so negedge+2 shows exactly what the next edge samples.
    always @(negedge clk) begin
        #2;
        if (rst_i) begin
            exp_q.delete();
        end else begin
            cyc++;
            chk("in_ready", 32'(in_ready_o),
                32'((exp_q.size() == 0) || ((exp_q.size() == 1) && out_ready_i)));
            chk("out_valid", 32'(out_valid_o), 32'(exp_q.size() != 0));
            if (out_valid_o && (exp_q.size() != 0)) begin
                chk("beat_data", 32'(out_data_o), 32'(exp_q[0].d));
                chk("beat_last", 32'(out_last_o), 32'(exp_q[0].l));
                chk("beat_ovf",  32'(ovf_o),      32'(exp_q[0].o));
            end
            if (out_valid_o && out_ready_i) begin
                mon_b.d = out_data_o;
                mon_b.l = out_last_o;
                mon_b.o = ovf_o;
                mon_b.c = cyc;
                got_q.push_back(mon_b);
                n_got_beats++;
                if (exp_q.size() != 0) void'(exp_q.pop_front());
            end
            if (in_valid_i && in_ready_o) model_push(in_data_i, mode_i, sign_i);
        end
    end

    task automatic drive(input logic v, input logic [31:0] d, input logic m, input logic s,
                         input logic r, output logic acc);
        @(negedge clk);
        in_valid_i  = v;
        in_data_i   = d;
        mode_i      = m;
        sign_i      = s;
        out_ready_i = r;
        #1;
        acc = v && in_ready_o;
    endtask

    task automatic idle(input int n, input logic r);
        logic acc;
        for (int i = 0; i < n; i++) drive(1'b0, 32'h0, 1'b0, 1'b0, r, acc);
    endtask

    task automatic chk_beat(input string name, input int idx, input logic [15:0] d,
                            input logic l, input logic o);
        if (got_q.size() > idx) begin
            chk({name, "_data"}, 32'(got_q[idx].d), 32'(d));
            chk({name, "_last"}, 32'(got_q[idx].l), 32'(l));
            chk({name, "_ovf"},  32'(got_q[idx].o), 32'(o));
        end else begin
            chk({name, "_present"}, 32'(got_q.size()), 32'(idx + 1));
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic acc, acc2;
        logic have;
        logic [31:0] w;
        logic [15:0] x;
        logic m, s, v;
        int sent, guard, first_c;

        edge_w[0] = 32'h0000_7FFF; edge_w[1] = 32'hFFFF_8000; edge_w[2] = 32'h0000_8000;
        edge_w[3] = 32'hFFFF_7FFF; edge_w[4] = 32'h0001_0000; edge_w[5] = 32'h0000_FFFF;

        rst_i = 1'b1; in_valid_i = 1'b0; in_data_i = '0; mode_i = 1'b0; sign_i = 1'b0; out_ready_i = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_out_valid", 32'(out_valid_o), 32'h0);
        chk("rst_out_data",  32'(out_data_o),  32'h0);
        chk("rst_out_last",  32'(out_last_o),  32'h0);
        chk("rst_ovf",       32'(ovf_o),       32'h0);
        chk("rst_in_ready",  32'(in_ready_o),  32'h1);
        @(negedge clk);
        rst_i = 1'b0;

        // SPLIT, no backpressure
        got_q.delete();
        drive(1'b1, 32'h1234_ABCD, 1'b0, 1'b0, 1'b1, acc);
        chk("t1_accept", 32'(acc), 32'h1);
        idle(3, 1'b1);
        chk("t1_beats", 32'(got_q.size()), 32'd2);
        chk_beat("t1_b0", 0, 16'hABCD, 1'b0, 1'b0);
        chk_beat("t1_b1", 1, 16'h1234, 1'b1, 1'b0);

        // NARROW signed back-to-back, no bubble
        got_q.delete();
        drive(1'b1, 32'hFFFF_8000, 1'b1, 1'b1, 1'b1, acc);
        drive(1'b1, 32'h0000_7FFF, 1'b1, 1'b1, 1'b1, acc2);
        chk("t2_accept0", 32'(acc), 32'h1);
        chk("t2_accept1", 32'(acc2), 32'h1);
        idle(2, 1'b1);
        chk("t2_beats", 32'(got_q.size()), 32'd2);
        chk_beat("t2_b0", 0, 16'h8000, 1'b1, 1'b0);
        chk_beat("t2_b1", 1, 16'h7FFF, 1'b1, 1'b0);
        if (got_q.size() >= 2) chk("t2_no_bubble", 32'(got_q[1].c - got_q[0].c), 32'd1);

        // NARROW overflow, signed and unsigned
        got_q.delete();
        drive(1'b1, 32'h0001_0000, 1'b1, 1'b1, 1'b1, acc);
        drive(1'b1, 32'hFFFF_0005, 1'b1, 1'b0, 1'b1, acc2);
        idle(2, 1'b1);
        chk("t3_beats", 32'(got_q.size()), 32'd2);
        chk_beat("t3_signed",   0, T3A_DATA, 1'b1, 1'b1);
        chk_beat("t3_unsigned", 1, T3B_DATA, 1'b1, 1'b1);

        // Backpressure on both SPLIT beats
        got_q.delete();
        drive(1'b1, 32'hAAAA_5555, 1'b0, 1'b0, 1'b0, acc);
        chk("t4_accept", 32'(acc), 32'h1);
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, acc);
            chk("t4_lo_in_ready", 32'(in_ready_o), 32'h0);
            chk("t4_lo_data",     32'(out_data_o), 32'h5555);
            chk("t4_lo_last",     32'(out_last_o), 32'h0);
        end
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, acc);
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, acc);
            chk("t4_hi_in_ready", 32'(in_ready_o), 32'h0);
            chk("t4_hi_data",     32'(out_data_o), 32'hAAAA);
            chk("t4_hi_last",     32'(out_last_o), 32'h1);
        end
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, acc);
        idle(1, 1'b1);
        chk("t4_beats", 32'(got_q.size()), 32'd2);
        chk_beat("t4_b0", 0, 16'h5555, 1'b0, 1'b0);
        chk_beat("t4_b1", 1, 16'hAAAA, 1'b1, 1'b0);

        // Asynchronous reset while the high beat is shown
        drive(1'b1, 32'h0BAD_F00D, 1'b0, 1'b0, 1'b1, acc);
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, acc);
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, acc);
        chk("t5_hi_data", 32'(out_data_o), 32'h0BAD);
        chk("t5_hi_last", 32'(out_last_o), 32'h1);
        @(negedge clk);
        rst_i = 1'b1;
        #1;
        chk("t5_rst_valid",    32'(out_valid_o), 32'h0);
        chk("t5_rst_in_ready", 32'(in_ready_o),  32'h1);
        chk("t5_rst_data",     32'(out_data_o),  32'h0);
        chk("t5_rst_last",     32'(out_last_o),  32'h0);
        @(negedge clk);
        rst_i = 1'b0;
        got_q.delete();
        drive(1'b1, 32'h0000_1234, 1'b1, 1'b0, 1'b1, acc);
        idle(2, 1'b1);
        chk("t5_beats", 32'(got_q.size()), 32'd1);
        chk_beat("t5_after", 0, 16'h1234, 1'b1, 1'b0);

        // Random words against the model
        n_exp_beats = 0;
        n_got_beats = 0;
        sent = 0;
        guard = 0;
        have = 1'b0;
        w = '0; m = 1'b0; s = 1'b0;
        while ((sent < 10000) && (guard < 80000)) begin
            if (!have) begin
                x = 16'($urandom);
                case ($urandom_range(0, 3))
                    0:       w = $urandom;
                    1:       w = {{16{x[15]}}, x};
                    2:       w = {16'h0000, x};
                    default: w = edge_w[$urandom_range(0, 5)];
                endcase
                m = 1'($urandom_range(0, 1));
                s = 1'($urandom_range(0, 1));
                have = 1'b1;
            end
            v = ($urandom_range(0, 7) != 0);
            drive(v, v ? w : $urandom, m, s, ($urandom_range(0, 3) != 0), acc);
            if (acc) begin
                have = 1'b0;
                sent++;
            end
            guard++;
        end
        chk("t6_words_sent", 32'(sent), 32'd10000);
        idle(4, 1'b1);
        chk("t6_beat_count", 32'(n_got_beats), 32'(n_exp_beats));
        chk("t6_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
